// File: rtl/cursor_pkg.sv
// Shared types and edge arithmetic for the cursor overlay controller.
package cursor_pkg;

    localparam int COORD_W_DEFAULT = 12;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_L,
        DIR_R,
        DIR_U,
        DIR_D
    } dir_t;

    // One signed extra bit keeps under/overflow visible before clamping or wrapping.
    function automatic logic [COORD_W_DEFAULT-1:0] step_coord(
        input logic [COORD_W_DEFAULT-1:0] pos,
        input logic [COORD_W_DEFAULT-1:0] step,
        input logic                       neg,
        input int                         res,
        input logic                       wrap
    );
        logic signed [COORD_W_DEFAULT:0] sum;
        logic signed [COORD_W_DEFAULT:0] lim;
        lim = (COORD_W_DEFAULT+1)'(res);
        if (neg) begin
            sum = $signed({1'b0, pos}) - $signed({1'b0, step});
        end else begin
            sum = $signed({1'b0, pos}) + $signed({1'b0, step});
        end
        if (sum[COORD_W_DEFAULT]) begin
            sum = wrap ? (sum + lim) : '0;
        end else if (sum >= lim) begin
            sum = wrap ? (sum - lim) : (lim - (COORD_W_DEFAULT+1)'(1));
        end
        return sum[COORD_W_DEFAULT-1:0];
    endfunction

endpackage

// File: rtl/cursor_hit_decoder.sv
// Maps a cursor position onto the menu column: reports whether it sits on a row and which one.
module cursor_hit_decoder
    import cursor_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int N_ITEMS = 5,
    parameter int MENU_X0 = 1110,
    parameter int MENU_X1 = 1150,
    parameter int MENU_Y0 = 691,
    parameter int ROW_H   = 25,
    localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic [COORD_W-1:0] cur_x_i,
    input  logic [COORD_W-1:0] cur_y_i,
    output logic               hit_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        if (int'(cur_x_i) >= MENU_X0 && int'(cur_x_i) <= MENU_X1) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (int'(cur_y_i) >= MENU_Y0 + i * ROW_H &&
                    int'(cur_y_i) <  MENU_Y0 + (i + 1) * ROW_H) begin
                    hit_o = 1'b1;
                    idx_o = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/cursor_nav_ctrl.sv
// On-screen cursor controller: accelerating button moves with clamp/wrap edges, menu click
// toggles, a freezable marker copy of the position and a registered crosshair pixel flag.
module cursor_nav_ctrl
    import cursor_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEFAULT,
    parameter int H_RES       = 1280,
    parameter int V_RES       = 1024,
    parameter int HOME_X      = 640,
    parameter int HOME_Y      = 512,
    parameter int ACCEL_DELAY = 3,
    parameter int MAX_STEP    = 64,
    parameter int WRAP        = 0,
    parameter int N_ITEMS     = 5,
    parameter int MENU_X0     = 1110,
    parameter int MENU_X1     = 1150,
    parameter int MENU_Y0     = 691,
    parameter int ROW_H       = 25,
    parameter logic [N_ITEMS-1:0] TOGGLE_INIT = '1,
    parameter int ARM         = 10,
    localparam int IDX_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               move_tick,
    input  logic               btnL,
    input  logic               btnR,
    input  logic               btnU,
    input  logic               btnD,
    input  logic               btnC,
    input  logic               freeze,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic [COORD_W-1:0] mark_x,
    output logic [COORD_W-1:0] mark_y,
    output logic [N_ITEMS-1:0] toggle_q,
    output logic               sel_valid,
    output logic [IDX_W-1:0]   sel_idx,
    output logic               pix_on
);

    localparam int HOLD_W = $clog2(ACCEL_DELAY + 1);
    localparam int SPD_W  = (MAX_STEP > 1) ? $clog2(MAX_STEP) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(ACCEL_DELAY);
    localparam logic [SPD_W-1:0]   SPEED_MAX = SPD_W'(MAX_STEP - 1);
    localparam logic [COORD_W-1:0] ARM_C     = COORD_W'(ARM);
    localparam logic               WRAP_EN   = (WRAP != 0);

    dir_t               dir, dir_q, dir_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, mark_x_q, mark_y_q, step, dx, dy;
    logic [HOLD_W-1:0]  hold_q, hold_d, hold_base;
    logic [SPD_W-1:0]   speed_q, speed_d, speed_base;
    logic [N_ITEMS-1:0] tog_q;
    logic [IDX_W-1:0]   hit_idx, sel_idx_q;
    logic               c_q, rise, hit, sel_valid_q, pix_q, pix_d;

    // A move needs exactly one direction button and no select; anything else is "no direction".
    always_comb begin
        case ({btnL, btnR, btnU, btnD})
            4'b1000: dir = DIR_L;
            4'b0100: dir = DIR_R;
            4'b0010: dir = DIR_U;
            4'b0001: dir = DIR_D;
            default: dir = DIR_NONE;
        endcase
        if (btnC || !en) dir = DIR_NONE;
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        hold_d     = hold_q;
        speed_d    = speed_q;
        dir_d      = dir_q;
        hold_base  = '0;
        speed_base = '0;
        step       = '0;
        if (dir == DIR_NONE) begin
            hold_d  = '0;
            speed_d = '0;
            dir_d   = DIR_NONE;
        end else if (move_tick) begin
            // Switching direction since the previous tick restarts acceleration from step 1.
            if (dir == dir_q) begin
                hold_base  = hold_q;
                speed_base = speed_q;
            end
            step    = COORD_W'(speed_base) + COORD_W'(1);
            hold_d  = (hold_base == HOLD_MAX) ? hold_base : hold_base + HOLD_W'(1);
            speed_d = (hold_d == HOLD_MAX && speed_base != SPEED_MAX) ?
                      speed_base + SPD_W'(1) : speed_base;
            dir_d   = dir;
            case (dir)
                DIR_L:   x_d = step_coord(x_q, step, 1'b1, H_RES, WRAP_EN);
                DIR_R:   x_d = step_coord(x_q, step, 1'b0, H_RES, WRAP_EN);
                DIR_U:   y_d = step_coord(y_q, step, 1'b1, V_RES, WRAP_EN);
                DIR_D:   y_d = step_coord(y_q, step, 1'b0, V_RES, WRAP_EN);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= COORD_W'(HOME_X);
            y_q     <= COORD_W'(HOME_Y);
            hold_q  <= '0;
            speed_q <= '0;
            dir_q   <= DIR_NONE;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hold_q  <= hold_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
        end
    end

    cursor_hit_decoder #(
        .COORD_W (COORD_W),
        .N_ITEMS (N_ITEMS),
        .MENU_X0 (MENU_X0),
        .MENU_X1 (MENU_X1),
        .MENU_Y0 (MENU_Y0),
        .ROW_H   (ROW_H)
    ) u_hit (
        .cur_x_i (x_q),
        .cur_y_i (y_q),
        .hit_o   (hit),
        .idx_o   (hit_idx)
    );

    assign rise = btnC & ~c_q & en & ~(btnL | btnR | btnU | btnD);

    // Arms are measured as unsigned distances, so they never wrap across screen edges.
    always_comb begin
        dx    = (px >= x_q) ? (px - x_q) : (x_q - px);
        dy    = (py >= y_q) ? (py - y_q) : (y_q - py);
        pix_d = en & (((px == x_q) & (dy <= ARM_C)) | ((py == y_q) & (dx <= ARM_C)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q         <= 1'b0;
            tog_q       <= TOGGLE_INIT;
            sel_valid_q <= 1'b0;
            sel_idx_q   <= '0;
            mark_x_q    <= COORD_W'(HOME_X);
            mark_y_q    <= COORD_W'(HOME_Y);
            pix_q       <= 1'b0;
        end else begin
            c_q         <= btnC;
            sel_valid_q <= rise & hit;
            if (rise && hit) begin
                tog_q     <= tog_q ^ (N_ITEMS'(1) << hit_idx);
                sel_idx_q <= hit_idx;
            end
            if (!freeze) begin
                mark_x_q <= x_q;
                mark_y_q <= y_q;
            end
            pix_q <= pix_d;
        end
    end

    assign cur_x     = x_q;
    assign cur_y     = y_q;
    assign mark_x    = mark_x_q;
    assign mark_y    = mark_y_q;
    assign toggle_q  = tog_q;
    assign sel_valid = sel_valid_q;
    assign sel_idx   = sel_idx_q;
    assign pix_on    = pix_q;

endmodule
